// File: rtl/ec130_timing_gen_if.sv
// Handshake bundle for the EC-130 timing generator: control inputs and
// registered phase/word/bit-time outputs.
interface ec130_timing_gen_if #(
  parameter int unsigned NPHASE   = 4,
  parameter int unsigned WORD_LEN = 4
);
  localparam int unsigned BW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  logic              run;
  logic              step_p;
  logic              word_clr;
  logic [NPHASE-1:0] phase_p;
  logic              word_p;
  logic [BW-1:0]     bit_cnt;
  logic              busy;

  modport master (
    output run, step_p, word_clr,
    input  phase_p, word_p, bit_cnt, busy
  );

  modport slave (
    input  run, step_p, word_clr,
    output phase_p, word_p, bit_cnt, busy
  );
endinterface

// File: rtl/ec130_timing_gen.sv
// EC-130 master timing generator: one-hot phase pulses, bit times and words.
// Optional completed-cycle counter output enabled by EC130_TIMING_GEN_CYC_CNT_EN.
module ec130_timing_gen #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned PW       = 2,
  parameter int unsigned NPHASE   = 4,
  parameter int unsigned WORD_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  ec130_timing_gen_if.slave bus
`ifdef EC130_TIMING_GEN_CYC_CNT_EN
  ,
  output logic [15:0]       cyc_cnt
`endif
);

  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PHW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam int unsigned BW  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0]  PW_C    = CW'(PW);
  localparam logic [PHW-1:0] PH_MAX  = PHW'(NPHASE - 1);
  localparam logic [BW-1:0]  BIT_MAX = BW'(WORD_LEN - 1);

  if (DIV < 2) begin : g_bad_div
    $error("ec130_timing_gen: DIV must be >= 2");
  end
  if (PW < 1 || PW >= DIV) begin : g_bad_pw
    $error("ec130_timing_gen: PW must be in 1..DIV-1");
  end
  if (NPHASE < 2) begin : g_bad_nphase
    $error("ec130_timing_gen: NPHASE must be >= 2");
  end
  if (WORD_LEN < 2) begin : g_bad_word_len
    $error("ec130_timing_gen: WORD_LEN must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PHW-1:0]    ph, ph_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic              step_prev;
  logic              step_edge;
  logic              active;
  logic              cyc_end;
  logic [NPHASE-1:0] phase_n;
  logic              word_n;
  logic [NPHASE-1:0] phase_q;
  logic              word_q;
  logic              busy_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ph_n      = ph;
    bit_n     = bit_q;
    step_edge = bus.step_p & ~step_prev;
    active    = (state != IDLE);
    cyc_end   = active && (cnt == CNT_MAX) && (ph == PH_MAX);

    if (active) begin
      if (cnt == CNT_MAX) begin
        cnt_n = '0;
        ph_n  = (ph == PH_MAX) ? '0 : ph + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      if (cyc_end) begin
        bit_n = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (bus.run) begin
          state_n = RUN;
        end else if (step_edge) begin
          state_n = STEP;
        end else if (bus.word_clr) begin
          bit_n = '0;
        end
      end
      RUN: begin
        if (!bus.run) state_n = DRAIN;
      end
      DRAIN: begin
        // Reasserting run resumes counting from the current slot, so the
        // pulse train has no gap even if this edge is also the cycle end.
        if (bus.run) begin
          state_n = RUN;
        end else if (cyc_end) begin
          state_n = IDLE;
        end
      end
      STEP: begin
        if (cyc_end) state_n = bus.run ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, so they
  // line up with state/cnt/ph and carry no input-to-output path.
  always_comb begin
    phase_n = '0;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      phase_n[i] = (state_n != IDLE) && (ph_n == PHW'(i)) && (cnt_n < PW_C);
    end
    word_n = phase_n[NPHASE-1] && (bit_n == BIT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ph        <= '0;
      bit_q     <= '0;
      step_prev <= 1'b0;
      phase_q   <= '0;
      word_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ph        <= ph_n;
      bit_q     <= bit_n;
      step_prev <= bus.step_p;
      phase_q   <= phase_n;
      word_q    <= word_n;
      busy_q    <= (state_n != IDLE);
    end
  end

`ifdef EC130_TIMING_GEN_CYC_CNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (cyc_end && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

  assign bus.phase_p = phase_q;
  assign bus.word_p  = word_q;
  assign bus.bit_cnt = bit_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ec130_timing_gen.sv
// Self-checking bench for ec130_timing_gen: directed vector table, hand
// sequences for multi-cycle corners, and random stimulus against a model.
module tb_ec130_timing_gen;
  localparam int unsigned DIV      = 4;
  localparam int unsigned PW       = 2;
  localparam int unsigned NPHASE   = 4;
  localparam int unsigned WORD_LEN = 4;
  localparam int unsigned CYC      = DIV * NPHASE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ec130_timing_gen_if #(.NPHASE(NPHASE), .WORD_LEN(WORD_LEN)) bus ();

`ifdef EC130_TIMING_GEN_CYC_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  ec130_timing_gen #(
    .DIV(DIV), .PW(PW), .NPHASE(NPHASE), .WORD_LEN(WORD_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef EC130_TIMING_GEN_CYC_CNT_EN
    ,
    .cyc_cnt(cyc_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one position counter over the whole timing cycle.
  int m_mode; // 0 idle, 1 run, 2 step, 3 drain
  int m_pos;
  int m_bits;
  int m_cyc;
  bit m_prev;

  task automatic model_update(input bit r, input bit ru, input bit s, input bit c);
    bit edge_s;
    bit last;
    if (r) begin
      m_mode = 0; m_pos = 0; m_bits = 0; m_cyc = 0; m_prev = 0;
    end else begin
      edge_s = s && !m_prev;
      m_prev = s;
      if (m_mode == 0) begin
        if (ru) m_mode = 1;
        else if (edge_s) m_mode = 2;
        else if (c) m_bits = 0;
      end else begin
        last  = (m_pos == CYC - 1);
        m_pos = last ? 0 : m_pos + 1;
        if (last) begin
          m_bits = (m_bits + 1) % WORD_LEN;
          if (m_cyc < 65535) m_cyc++;
        end
        case (m_mode)
          1: if (!ru) m_mode = 3;
          3: if (ru) m_mode = 1; else if (last) m_mode = 0;
          2: if (last) m_mode = ru ? 1 : 0;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [NPHASE-1:0] m_phase();
    logic [NPHASE-1:0] p;
    p = '0;
    if (m_mode != 0 && (m_pos % DIV) < PW) p[m_pos / DIV] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit ru, input bit s, input bit c);
    rst = r; bus.run = ru; bus.step_p = s; bus.word_clr = c;
    @(posedge clk);
    #1;
    model_update(r, ru, s, c);
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    logic [NPHASE-1:0] p;
    p = m_phase();
    chk({tag, ".phase_p"}, 32'(bus.phase_p), 32'(p));
    chk({tag, ".word_p"}, 32'(bus.word_p), 32'(p[NPHASE-1] && m_bits == WORD_LEN - 1));
    chk({tag, ".bit_cnt"}, 32'(bus.bit_cnt), 32'(m_bits));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_mode != 0));
`ifdef EC130_TIMING_GEN_CYC_CNT_EN
    chk({tag, ".cyc_cnt"}, 32'(cyc_cnt), 32'(m_cyc));
`endif
  endtask

  typedef struct {
    bit         r, ru, s, c;
    logic [3:0] ph;
    logic       w;
    logic [1:0] bc;
    logic       bz;
  } vec_t;

  function automatic vec_t v(input bit r, input bit ru, input bit s, input bit c,
                             input logic [3:0] ph, input logic w,
                             input logic [1:0] bc, input logic bz);
    vec_t x;
    x.r = r; x.ru = ru; x.s = s; x.c = c; x.ph = ph; x.w = w; x.bc = bc; x.bz = bz;
    return x;
  endfunction

  initial begin
    vec_t tbl[$];
    int   cnt_a, cnt_b, bad;
    logic [NPHASE-1:0] prev_ph;
    bit   r, ru, s, c;

    // rst, run, step, clr -> phase_p, word_p, bit_cnt, busy after the edge
    tbl.push_back(v(1,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(1,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(1,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,0,0, 4'b0001,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0001,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0010,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0010,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0100,0,0,1));
    tbl.push_back(v(0,1,0,0, 4'b0100,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b1000,0,0,1));
    tbl.push_back(v(0,0,0,1, 4'b1000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0, 4'b0000,0,1,0));
    tbl.push_back(v(0,0,0,1, 4'b0000,0,0,0));
    tbl.push_back(v(0,0,1,0, 4'b0001,0,0,1));
    tbl.push_back(v(0,0,1,0, 4'b0001,0,0,1));
    tbl.push_back(v(1,0,1,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,0,0, 4'b0001,0,0,1));
    tbl.push_back(v(1,0,0,0, 4'b0000,0,0,0));

    rst = 1'b1; bus.run = 1'b0; bus.step_p = 1'b0; bus.word_clr = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].ru, tbl[i].s, tbl[i].c);
      chk($sformatf("vec%0d.phase_p", i), 32'(bus.phase_p), 32'(tbl[i].ph));
      chk($sformatf("vec%0d.word_p", i), 32'(bus.word_p), 32'(tbl[i].w));
      chk($sformatf("vec%0d.bit_cnt", i), 32'(bus.bit_cnt), 32'(tbl[i].bc));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(tbl[i].bz));
    end

    // Idle after reset stays quiet for 20 clocks
    tick(1, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      if (bus.phase_p != 0 || bus.word_p || bus.busy || bus.bit_cnt != 0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Free run: bit_cnt steps after 16 clocks, word_p 2 clocks per 64
    tick(1, 0, 0, 0);
    cnt_a = 0; bad = 0;
    for (int i = 0; i < 128; i++) begin
      tick(0, 1, 0, 0);
      if (i == 15) chk("run_bit_before", 32'(bus.bit_cnt), 32'd0);
      if (i == 16) chk("run_bit_after", 32'(bus.bit_cnt), 32'd1);
      if (bus.word_p) cnt_a++;
      if (bus.word_p != (bus.phase_p[NPHASE-1] && bus.bit_cnt == 2'd3)) bad++;
    end
    chk("word_p_count", 32'(cnt_a), 32'd4);
    chk("word_p_align", 32'(bad), 32'd0);

    // step_p held high for 30 clocks gives a single timing cycle
    tick(1, 0, 0, 0);
    cnt_a = 0; cnt_b = 0; prev_ph = '0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 1, 0);
      if (bus.busy) cnt_a++;
      if (bus.phase_p != 0 && prev_ph == 0) cnt_b++;
      prev_ph = bus.phase_p;
    end
    chk("step_busy_clks", 32'(cnt_a), 32'(CYC));
    chk("step_pulses", 32'(cnt_b), 32'(NPHASE));
    chk("step_bit1", 32'(bus.bit_cnt), 32'd1);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 1, 0);
    chk("step_bit2", 32'(bus.bit_cnt), 32'd2);
    tick(0, 0, 0, 1);
    chk("word_clr_idle", 32'(bus.bit_cnt), 32'd0);

    // rst mid-cycle at cnt=1, ph=2 then restart
    tick(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    chk("pre_rst_phase", 32'(bus.phase_p), 32'b0100);
    tick(1, 1, 0, 0);
    chk("mid_rst_phase", 32'(bus.phase_p), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    tick(0, 1, 0, 0);
    chk("restart_phase", 32'(bus.phase_p), 32'b0001);

`ifdef EC130_TIMING_GEN_CYC_CNT_EN
    tick(1, 0, 0, 0);
    for (int i = 0; i < 161; i++) tick(0, 1, 0, 0);
    chk("cyc_cnt_10", 32'(cyc_cnt), 32'd10);
`endif

    // Randomized traffic against the model
    tick(1, 0, 0, 0);
    ru = 0; s = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 400) == 0;
      if (($urandom % 24) == 0) ru = !ru;
      if (($urandom % 6) == 0) s = !s;
      c = ($urandom % 8) == 0;
      tick(r, ru, s, c);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ec130_timing_gen.md
Name: ec130_timing_gen

Overview:
- Master timing generator for the EC-130 model. Divides the system clock into a repeating cycle of NPHASE one-hot phase pulses and counts cycles into bit times and words.
- Its pulse outputs drive the pulse-sensitive (rising-edge-detected) set/reset/toggle inputs of the machine's flip-flops.
- Supports free-run, controlled stop at a cycle boundary, and single-cycle stepping.

Parameters:
- DIV, 4: clk cycles per phase slot; legal range ≥2.
- PW, 2: clk cycles each phase pulse is high; legal range 1..DIV-1, so a low gap precedes every pulse for downstream edge detection.
- NPHASE, 4: phase slots per timing cycle; legal range ≥2.
- WORD_LEN, 4: timing cycles (bit times) per word; legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level; high requests free-running cycles.
- step_p  in  1  pulse; a rising edge while idle requests exactly one timing cycle.
- word_clr  in  1  level; clears the bit counter, honoured only in IDLE.
- phase_p  out  NPHASE  one-hot phase pulses.
- word_p  out  1  end-of-word pulse.
- bit_cnt  out  clog2(WORD_LEN)  current bit time within the word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clocking:
  - The single clock is clk. Reset rst is synchronous and active-high.
  - Reset state: IDLE. Prescaler cnt=0, slot ph=0, bit_cnt=0, step-edge history=0. All outputs 0.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Counters (advance only in RUN, STEP and DRAIN):
  - cnt counts 0..DIV-1, then wraps.
  - ph advances when cnt==DIV-1 and wraps NPHASE-1→0.
  - Cycle end: cnt==DIV-1 and ph==NPHASE-1.
  - At each cycle end, bit_cnt increments, wrapping WORD_LEN-1→0.
- Pulse outputs:
  - phase_p[ph]=1 while cnt<PW in an active state; all other bits are 0.
  - word_p=1 exactly when phase_p[NPHASE-1]=1 and bit_cnt==WORD_LEN-1.
- Step edge detection: a step_p edge is prev_step_p==0 && step_p==1, registered each clk in every state.
- State machine:
  - IDLE:
    - cnt=0, ph=0, outputs 0 except bit_cnt.
    - run=1 → RUN.
    - Otherwise, step edge → STEP.
    - Otherwise, word_clr=1 → bit_cnt=0.
    - run takes priority over a step edge in the same cycle.
  - RUN:
    - Counting.
    - run=0 sampled → DRAIN, mid-cycle or not.
  - DRAIN:
    - Counting continues.
    - run=1 → RUN, with no gap in the pulse train.
    - At cycle end → IDLE; cnt and ph return to 0 and bit_cnt keeps its incremented value.
  - STEP:
    - Counting; run and step edges are ignored.
    - At cycle end, run=1 → RUN with a seamless continuation.
    - At cycle end, run=0 → IDLE.
- Latency:
  - run sampled high at edge N puts phase_p[0]=1 in the cycle after edge N (state RUN, cnt=0).
  - A step edge behaves the same way.
- One full timing cycle lasts DIV*NPHASE clks.
- A cycle is never truncated except by rst. Stop and step always end at a cycle boundary.
- rst mid-cycle: everything returns to reset values on the next edge, and phase_p drops immediately after that edge.
- Holding step_p high produces one cycle only; another step requires step_p to go low and then high again.
- word_clr outside IDLE is ignored.

Optional Feature:
- Macro: EC130_TIMING_GEN_CYC_CNT_EN.
- Defined:
  - Adds output cyc_cnt [15:0].
  - Counts completed timing cycles and saturates at 16'hFFFF.
  - Cleared by rst only.
  - Increments at the same edge as bit_cnt.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- rst held 3 clks, then released with run=0 → phase_p=0, word_p=0, busy=0, bit_cnt=0 for 20 clks.
- run=1 from edge N with defaults → phase_p=0001 for 2 clks, 0 for 2, then 0010, 0100, 1000 in the same pattern. After 16 clks bit_cnt=1. word_p pulses 2 clks every 64 clks, coinciding with phase_p[3] when bit_cnt=3.
- run dropped during slot 1 → pulses continue through phase_p[3], then busy=0, cnt=ph=0, bit_cnt advanced by 1. run reasserted during DRAIN → no gap in the pulse train.
- step_p high for 30 clks while idle → exactly one 16-clk cycle, 4 pulses, bit_cnt 0→1. A second step_p rising edge → bit_cnt=2. word_clr=1 in IDLE → bit_cnt=0.
- rst asserted at cnt=1, ph=2 in RUN → next cycle: all outputs 0, state IDLE; with run=1 restart → phase_p[0] first.
- With EC130_TIMING_GEN_CYC_CNT_EN, run for 1,048,576+ clks → cyc_cnt saturates at FFFF; after 160 clks of run from reset → cyc_cnt=10.
